// File: rtl/board_io_ctrl.sv
// board_io_ctrl: board-level front end for the cpu core.
// This block does three jobs:
//  - Holds the core in reset for a programmable number of cycles after the
//    external reset releases or after a soft reset request.
//  - Synchronises and debounces the slide switches.
//  - Registers the cpu LED value onto the board pins.
module board_io_ctrl #(
  parameter int SW_WIDTH        = 16,
  parameter int LED_WIDTH       = 16,
  parameter int RST_HOLD_CYCLES = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 soft_rst_req,
  input  logic [SW_WIDTH-1:0]  sw_raw,
  input  logic [LED_WIDTH-1:0] cpu_led,
  output logic                 cpu_rst,
  output logic [SW_WIDTH-1:0]  sw_out,
  output logic                 sw_change,
  output logic [LED_WIDTH-1:0] led_out,
  output logic                 ready
);

  localparam logic STATE_HOLD = 1'b0;
  localparam logic STATE_RUN  = 1'b1;

  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  logic                state;
  logic                state_next;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_next;

  logic [SW_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [SW_WIDTH-1:0] synced;
  logic [DB_W-1:0]     db_cnt  [SW_WIDTH];
  logic [DB_W-1:0]     db_next [SW_WIDTH];
  logic [SW_WIDTH-1:0] accept;
  logic [SW_WIDTH-1:0] sw_next;

  assign synced = sync_q[SYNC_STAGES-1];

  // Reset sequencer. A soft request always restarts the hold from zero,
  // whether it arrives in RUN or part way through an existing hold.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    if (state == STATE_HOLD) begin
      if (soft_rst_req) begin
        hold_next = '0;
      end else if (hold_cnt == HOLD_LAST) begin
        state_next = STATE_RUN;
        hold_next  = '0;
      end else begin
        hold_next = hold_cnt + HOLD_W'(1);
      end
    end else if (soft_rst_req) begin
      state_next = STATE_HOLD;
      hold_next  = '0;
    end
  end

  // cpu_rst and ready come from the next state so that they change on the
  // same edge as the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= STATE_HOLD;
      hold_cnt <= '0;
      cpu_rst  <= 1'b1;
      ready    <= 1'b0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      cpu_rst  <= (state_next == STATE_HOLD);
      ready    <= (state_next == STATE_RUN);
    end
  end

  // Multi-flop synchroniser chain for every switch pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= sw_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Per-bit debounce. A bit is accepted only after the synced value has
  // disagreed with sw_out for DEBOUNCE_CYCLES edges in a row.
  // Any agreement clears the run.
  always_comb begin
    sw_next = sw_out;
    accept  = '0;
    for (int i = 0; i < SW_WIDTH; i++) begin
      db_next[i] = '0;
      if (synced[i] != sw_out[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          sw_next[i] = synced[i];
          accept[i]  = 1'b1;
        end else begin
          db_next[i] = db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Debounced switch register. The change strobe is suppressed whenever
  // the core is held in reset, although sw_out keeps tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_out    <= '0;
      sw_change <= 1'b0;
      for (int i = 0; i < SW_WIDTH; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sw_out    <= sw_next;
      sw_change <= (|accept) && (state_next == STATE_RUN);
      for (int i = 0; i < SW_WIDTH; i++) begin
        db_cnt[i] <= db_next[i];
      end
    end
  end

  // LEDs follow the cpu while it runs.
  // The LEDs go dark on the edge that takes a soft reset request.
  // They stay dark for the whole hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out <= '0;
    end else if (state == STATE_RUN && !soft_rst_req) begin
      led_out <= cpu_led;
    end else begin
      led_out <= '0;
    end
  end

endmodule
